// File: rtl/uart_core.sv
// Full-duplex UART: parametrised TX/RX framing, RX error flags and show-ahead RX FIFO.
// One clock domain; i_rx is synchronised internally.
module uart_core #(
  parameter int ClockFrequency = 15_000_000,
  parameter int BaudRate       = 115200,
  parameter int DataBits       = 8,
  parameter int ParityMode     = 0,
  parameter int StopBits       = 1,
  parameter int RxSyncStages   = 2,
  parameter int RxFifoDepth    = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_tx_valid,
  output logic                               o_tx_ready,
  input  logic [DataBits-1:0]                i_tx_data,
  output logic                               o_tx,
  output logic                               o_tx_busy,
  input  logic                               i_rx,
  output logic                               o_rx_valid,
  input  logic                               i_rx_ready,
  output logic [DataBits-1:0]                o_rx_data,
  output logic                               o_rx_parity_err,
  output logic                               o_rx_frame_err,
  output logic                               o_overrun,
  input  logic                               i_clear_err,
  output logic [$clog2(RxFifoDepth+1)-1:0]   o_rx_count
);

  localparam int Div = ClockFrequency / BaudRate;
  localparam int TW  = $clog2(Div);
  localparam int AW  = $clog2(RxFifoDepth);
  localparam int CW  = $clog2(RxFifoDepth + 1);
  localparam int EW  = DataBits + 2;
  localparam bit HasParity = (ParityMode != 0);
  localparam bit ParOdd    = (ParityMode == 2);
  localparam logic [TW-1:0] DivLast  = TW'(Div - 1);
  localparam logic [TW-1:0] HalfLast = TW'(Div / 2 - 1);
  localparam logic [3:0]    LastData = 4'(DataBits - 1);
  localparam logic [3:0]    LastStop = 4'(StopBits - 1);
  localparam logic [CW-1:0] Full     = CW'(RxFifoDepth);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // ---------------- TX ----------------
  state_t              tx_state;
  logic [TW-1:0]       tx_cnt;
  logic [3:0]          tx_bit;
  logic [DataBits-1:0] tx_sh;
  logic                tx_par;
  logic                tx_q;
  logic                tx_end;

  assign o_tx_ready = (tx_state == S_IDLE);
  assign o_tx_busy  = !o_tx_ready;
  assign o_tx       = tx_q;
  assign tx_end     = (tx_cnt == DivLast);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      if (tx_state != S_IDLE)
        tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
      unique case (tx_state)
        S_IDLE: if (i_tx_valid) begin
          tx_state <= S_START;
          tx_q     <= 1'b0;
          tx_sh    <= i_tx_data;
          tx_par   <= ParOdd ^ (^i_tx_data);
          tx_cnt   <= '0;
        end
        S_START: if (tx_end) begin
          tx_state <= S_DATA;
          tx_q     <= tx_sh[0];
          tx_bit   <= '0;
        end
        S_DATA: if (tx_end) begin
          if (tx_bit == LastData) begin
            tx_bit <= '0;
            if (HasParity) begin
              tx_state <= S_PARITY;
              tx_q     <= tx_par;
            end else begin
              tx_state <= S_STOP;
              tx_q     <= 1'b1;
            end
          end else begin
            tx_bit <= tx_bit + 1'b1;
            tx_sh  <= tx_sh >> 1;
            tx_q   <= tx_sh[1];
          end
        end
        S_PARITY: if (tx_end) begin
          tx_state <= S_STOP;
          tx_q     <= 1'b1;
          tx_bit   <= '0;
        end
        S_STOP: if (tx_end) begin
          if (tx_bit == LastStop) tx_state <= S_IDLE;
          else tx_bit <= tx_bit + 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [RxSyncStages-1:0] rx_sync;
  logic                    rx_s;
  logic                    rx_prev;
  state_t                  rx_state;
  logic [TW-1:0]           rx_cnt;
  logic [3:0]              rx_bit;
  logic [DataBits-1:0]     rx_sh;
  logic                    rx_perr;
  logic                    rx_ferr;
  logic                    rx_end;
  logic                    push;
  logic [EW-1:0]           push_entry;

  assign rx_s       = rx_sync[RxSyncStages-1];
  assign rx_end     = (rx_cnt == DivLast);
  assign push       = (rx_state == S_STOP) && rx_end && (rx_bit == LastStop);
  assign push_entry = {rx_ferr | !rx_s, rx_perr, rx_sh};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_sync  <= '1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[RxSyncStages-2:0], i_rx};
      rx_prev <= rx_s;
      if (rx_state != S_IDLE)
        rx_cnt <= rx_end ? '0 : rx_cnt + 1'b1;
      unique case (rx_state)
        // Edge-triggered start: a held-low line cannot retrigger.
        S_IDLE: if (rx_prev && !rx_s) begin
          rx_state <= S_START;
          rx_cnt   <= '0;
          rx_perr  <= 1'b0;
          rx_ferr  <= 1'b0;
        end
        S_START: if (rx_cnt == HalfLast) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_end) begin
          rx_sh <= {rx_s, rx_sh[DataBits-1:1]};
          if (rx_bit == LastData) begin
            rx_bit   <= '0;
            rx_state <= HasParity ? S_PARITY : S_STOP;
          end else begin
            rx_bit <= rx_bit + 1'b1;
          end
        end
        S_PARITY: if (rx_end) begin
          rx_perr  <= rx_s ^ ParOdd ^ (^rx_sh);
          rx_state <= S_STOP;
        end
        S_STOP: if (rx_end) begin
          rx_ferr <= rx_ferr | !rx_s;
          if (rx_bit == LastStop) rx_state <= S_IDLE;
          else rx_bit <= rx_bit + 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [EW-1:0]   mem [RxFifoDepth];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            pop;
  logic            push_ok;
  logic [EW-1:0]   head;

  assign o_rx_valid = (count != '0);
  assign pop        = o_rx_valid && i_rx_ready;
  assign push_ok    = push && ((count != Full) || pop);
  assign head       = o_rx_valid ? mem[rptr] : '0;
  assign o_rx_data       = head[DataBits-1:0];
  assign o_rx_parity_err = head[DataBits];
  assign o_rx_frame_err  = head[DataBits+1];
  assign o_rx_count      = count;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wptr] <= push_entry;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      if (push && !push_ok) o_overrun <= 1'b1;
      else if (i_clear_err) o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core at DIV = 16, 8E1, 4-entry RX FIFO.
// Each task drives one scenario and checks its own results inline.
module tb_uart_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       tx_busy;
  logic       rx;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       overrun;
  logic       clear_err = 1'b0;
  logic [2:0] rx_count;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rx = loop ? tx : rx_drv;

  uart_core #(
    .ClockFrequency(1_600_000),
    .BaudRate(100_000),
    .DataBits(8),
    .ParityMode(1),
    .StopBits(1),
    .RxSyncStages(2),
    .RxFifoDepth(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready),
    .i_tx_data(tx_data),
    .o_tx(tx),
    .o_tx_busy(tx_busy),
    .i_rx(rx),
    .o_rx_valid(rx_valid),
    .i_rx_ready(rx_ready),
    .o_rx_data(rx_data),
    .o_rx_parity_err(rx_perr),
    .o_rx_frame_err(rx_ferr),
    .o_overrun(overrun),
    .i_clear_err(clear_err),
    .o_rx_count(rx_count)
  );

  task automatic tx_send(input logic [7:0] d);
    for (int i = 0; i < 400 && !tx_ready; i++) @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Leaves the line at the stop level, so stop_v = 0 models a break.
  task automatic rx_frame(input logic [7:0] d, input logic par_flip,
                          input logic stop_v);
    logic [10:0] f;
    f = {stop_v, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = f[i];
      repeat (16) @(negedge clk);
    end
    rx_drv = stop_v;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
    n_checks++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready); end
    n_checks++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_busy: got %b want 0", tx_busy); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
    n_checks++;
    if ({rx_perr, rx_ferr} !== 2'b00) begin n_fail++; $display("FAIL rst_rx_errs: got %b want 00", {rx_perr, rx_ferr}); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_checks++;
    if (rx_count !== 3'd0) begin n_fail++; $display("FAIL rst_rx_count: got %0d want 0", rx_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_frame();
    logic [10:0] f;
    int bad_bits;
    int bad_rdy;
    f = {1'b1, 1'b0, 8'hA5, 1'b0};
    bad_bits = 0;
    bad_rdy = 0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 176; i++) begin
      if (tx !== f[i/16]) bad_bits++;
      if (tx_ready !== 1'b0 || tx_busy !== 1'b1) bad_rdy++;
      @(negedge clk);
    end
    n_checks++;
    if (bad_bits !== 0) begin n_fail++; $display("FAIL tx_a5_bits: %0d wrong samples, want 0", bad_bits); end
    n_checks++;
    if (bad_rdy !== 0) begin n_fail++; $display("FAIL tx_a5_ready_low: %0d wrong samples, want 0", bad_rdy); end
    n_checks++;
    if (tx_ready !== 1'b1 || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_a5_ready_after: got ready=%b tx=%b want 1 1", tx_ready, tx);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h3C};
    loop = 1'b1;
    for (int k = 0; k < 3; k++) tx_send(exp[k]);
    for (int i = 0; i < 600 && rx_count < 3; i++) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd3) begin n_fail++; $display("FAIL loop_count: got %0d want 3", rx_count); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rx_data !== exp[k] || rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_entry%0d: got %h p=%b f=%b want %h 0 0", k, rx_data, rx_perr, rx_ferr, exp[k]);
      end
      pop_one();
    end
    n_checks++;
    if (rx_count !== 3'd0) begin n_fail++; $display("FAIL loop_drain: got %0d want 0", rx_count); end
    repeat (20) @(negedge clk);
    loop = 1'b0;
  endtask

  task automatic test_errors();
    rx_frame(8'h41, 1'b1, 1'b1);
    for (int i = 0; i < 60 && rx_count < 1; i++) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd1 || rx_data !== 8'h41 || rx_perr !== 1'b1 || rx_ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_err: got n=%0d %h p=%b f=%b want 1 41 1 0", rx_count, rx_data, rx_perr, rx_ferr);
    end
    pop_one();
    repeat (10) @(negedge clk);
    rx_frame(8'h41, 1'b0, 1'b0);
    for (int i = 0; i < 60 && rx_count < 1; i++) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd1 || rx_data !== 8'h41 || rx_perr !== 1'b0 || rx_ferr !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err: got n=%0d %h p=%b f=%b want 1 41 0 1", rx_count, rx_data, rx_perr, rx_ferr);
    end
    repeat (200) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd1) begin n_fail++; $display("FAIL break_no_retrigger: got %0d want 1", rx_count); end
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd1) begin n_fail++; $display("FAIL break_release: got %0d want 1", rx_count); end
    pop_one();
  endtask

  task automatic test_overrun();
    logic [7:0] d [5];
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 5; k++) begin
      rx_frame(d[k], 1'b0, 1'b1);
      repeat (4) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count: got %0d want 4", rx_count); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rx_data !== d[k] || rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin
        n_fail++;
        $display("FAIL ovr_entry%0d: got %h p=%b f=%b want %h 0 0", k, rx_data, rx_perr, rx_ferr, d[k]);
      end
      pop_one();
    end
    n_checks++;
    if (rx_count !== 3'd0) begin n_fail++; $display("FAIL ovr_drain: got %0d want 0", rx_count); end
  endtask

  task automatic test_glitch();
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_no_push: got n=%0d v=%b want 0 0", rx_count, rx_valid);
    end
    rx_frame(8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 60 && rx_count < 1; i++) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd1 || rx_data !== 8'h5A || rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_recover: got n=%0d %h p=%b f=%b want 1 5a 0 0", rx_count, rx_data, rx_perr, rx_ferr);
    end
    pop_one();
  endtask

  task automatic test_reset_mid_tx();
    loop = 1'b1;
    tx_send(8'hF0);
    repeat (71) @(negedge clk);
    n_checks++;
    if (tx !== 1'b0 || tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midtx_bit3: got tx=%b ready=%b want 0 0", tx, tx_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midtx_async_rst: got tx=%b ready=%b busy=%b want 1 1 0", tx, tx_ready, tx_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_send(8'h55);
    for (int i = 0; i < 400 && rx_count < 1; i++) @(negedge clk);
    n_checks++;
    if (rx_count !== 3'd1 || rx_data !== 8'h55 || rx_perr !== 1'b0 || rx_ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL midtx_next_frame: got n=%0d %h p=%b f=%b want 1 55 0 0", rx_count, rx_data, rx_perr, rx_ferr);
    end
    pop_one();
    loop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_errors();
    test_overrun();
    test_glitch();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
